// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states and
// flag bit positions within the 5-bit flags word.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_REM  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_DIV0    = 3;
    localparam int FLAG_ILLEGAL = 4;

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bus of the multi-cycle ALU; the master issues operations,
// the slave (alu_mc) reports readiness, progress and results.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             start;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [4:0]       flags;

    modport master (
        output A, B, opcode, start,
        input  ready, busy, result, result_valid, flags
    );

    modport slave (
        input  A, B, opcode, start,
        output ready, busy, result, result_valid, flags
    );
endinterface

// File: rtl/alu_mc_div.sv
// Serial unsigned restoring divider: the first quotient bit is resolved on the
// start edge, so done rises WIDTH-1 cycles later with quotient/remainder stable.
module alu_mc_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   d_r;
    logic [CW-1:0]      cnt_r;
    logic               run_r;
    logic [2*WIDTH-1:0] step_s;

    // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   trial_s;
        logic [WIDTH-1:0] q_s;
        trial_s = {r, q[WIDTH-1]};
        q_s     = {q[WIDTH-2:0], 1'b0};
        if (trial_s >= {1'b0, d}) begin
            trial_s = trial_s - {1'b0, d};
            q_s[0]  = 1'b1;
        end else begin
            q_s[0]  = 1'b0;
        end
        return {trial_s[WIDTH-1:0], q_s};
    endfunction

    assign step_s    = start ? div_step({WIDTH{1'b0}}, dividend, divisor) : div_step(r_r, q_r, d_r);
    assign done      = run_r && (cnt_r == CW'(WIDTH));
    assign quotient  = q_r;
    assign remainder = r_r;

    // Iteration registers; clear drops any division in progress.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            run_r <= 1'b0;
            cnt_r <= '0;
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
        end else if (start) begin
            run_r      <= 1'b1;
            cnt_r      <= CW'(1);
            d_r        <= divisor;
            {r_r, q_r} <= step_s;
        end else if (run_r && (cnt_r != CW'(WIDTH))) begin
            cnt_r      <= cnt_r + CW'(1);
            {r_r, q_r} <= step_s;
        end else begin
            run_r <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU behind the PMU power domain with isolation clamping.
// Define ALU_MC_DIV_EN to build the serial divider for opcodes 9/10 (else they are illegal).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    alu_pwr_en,
    input  logic    iso_en,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_r, state_s;
    logic [3:0]       cnt_r;
    logic [WIDTH-1:0] a_r, b_r, result_r, done_res_s;
    logic [4:0]       flags_r, done_flg_s;
    logic             valid_r, rdy_en_r, ready_s, issue_s, done_s;
    logic [WIDTH+4:0] eval_s, mul_s;
`ifdef ALU_MC_DIV_EN
    logic             rem_sel_r, div_start_s, div_done_s;
    logic [WIDTH-1:0] quot_s, rem_s;
`endif

    // Everything that completes without iterating; returns {flags, result}.
    function automatic logic [WIDTH+4:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0]       op);
        logic [WIDTH:0]     sum_s;
        logic [2*WIDTH-1:0] prod_s;
        logic [WIDTH-1:0]   res_s;
        logic [4:0]         flg_s;
        sum_s  = '0;
        prod_s = '0;
        res_s  = '0;
        flg_s  = 5'b00000;
        case (op)
            OP_ADD: begin
                sum_s = {1'b0, a} + {1'b0, b};
                res_s = sum_s[WIDTH-1:0];
                flg_s[FLAG_CARRY] = sum_s[WIDTH];
            end
            OP_SUB: begin
                res_s = a - b;
                flg_s[FLAG_CARRY] = (a < b);
            end
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_XOR:  res_s = a ^ b;
            OP_NOR:  res_s = ~(a | b);
            OP_SLL:  res_s = a << b[SHW-1:0];
            OP_XNOR: res_s = ~(a ^ b);
            OP_MUL: begin
                prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                res_s  = prod_s[WIDTH-1:0];
                flg_s[FLAG_OVF] = |prod_s[2*WIDTH-1:WIDTH];
            end
`ifdef ALU_MC_DIV_EN
            // Only reached with a zero divisor; nonzero divisors go to the divider.
            OP_DIV: begin
                res_s = '1;
                flg_s[FLAG_DIV0] = 1'b1;
            end
            OP_REM: begin
                res_s = a;
                flg_s[FLAG_DIV0] = 1'b1;
            end
`endif
            default: flg_s[FLAG_ILLEGAL] = 1'b1;
        endcase
        flg_s[FLAG_ZERO] = (res_s == '0);
        return {flg_s, res_s};
    endfunction

    assign ready_s = rdy_en_r && alu_pwr_en && (state_r == ST_IDLE);
    assign issue_s = bus.start && ready_s;
    assign eval_s  = alu_eval(bus.A, bus.B, bus.opcode);
    assign mul_s   = alu_eval(a_r, b_r, OP_MUL);

`ifdef ALU_MC_DIV_EN
    alu_mc_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!alu_pwr_en),
        .start     (div_start_s),
        .dividend  (bus.A),
        .divisor   (bus.B),
        .done      (div_done_s),
        .quotient  (quot_s),
        .remainder (rem_s)
    );
`endif

    // Next state and completion value; losing power discards any completion this cycle.
    always_comb begin
        state_s    = state_r;
        done_s     = 1'b0;
        done_res_s = result_r;
        done_flg_s = flags_r;
`ifdef ALU_MC_DIV_EN
        div_start_s = 1'b0;
`endif
        if (!alu_pwr_en) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!issue_s) begin
                        state_s = ST_IDLE;
                    end else if ((bus.opcode == OP_MUL) && (MUL_LAT > 1)) begin
                        state_s = ST_MUL;
`ifdef ALU_MC_DIV_EN
                    end else if (((bus.opcode == OP_DIV) || (bus.opcode == OP_REM)) && (bus.B != '0)) begin
                        state_s     = ST_DIV;
                        div_start_s = 1'b1;
`endif
                    end else begin
                        done_s                   = 1'b1;
                        {done_flg_s, done_res_s} = eval_s;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == 4'(MUL_LAT - 1)) begin
                        state_s                  = ST_IDLE;
                        done_s                   = 1'b1;
                        {done_flg_s, done_res_s} = mul_s;
                    end else begin
                        state_s = ST_MUL;
                    end
                end
`ifdef ALU_MC_DIV_EN
                ST_DIV: begin
                    if (div_done_s) begin
                        state_s    = ST_IDLE;
                        done_s     = 1'b1;
                        done_res_s = rem_sel_r ? rem_s : quot_s;
                        done_flg_s = 5'b00000;
                        done_flg_s[FLAG_ZERO] = (done_res_s == '0);
                    end else begin
                        state_s = ST_DIV;
                    end
                end
`endif
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, operand capture, latency counter and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            a_r       <= '0;
            b_r       <= '0;
            result_r  <= '0;
            flags_r   <= 5'b00000;
            valid_r   <= 1'b0;
            rdy_en_r  <= 1'b0;
`ifdef ALU_MC_DIV_EN
            rem_sel_r <= 1'b0;
`endif
        end else begin
            rdy_en_r <= 1'b1;
            state_r  <= state_s;
            valid_r  <= done_s;
            if (done_s) begin
                result_r <= done_res_s;
                flags_r  <= done_flg_s;
            end
            if (!alu_pwr_en) begin
                cnt_r <= 4'd0;
            end else if (issue_s) begin
                cnt_r     <= 4'd1;
                a_r       <= bus.A;
                b_r       <= bus.B;
`ifdef ALU_MC_DIV_EN
                rem_sel_r <= (bus.opcode == OP_REM);
`endif
            end else if (state_r == ST_MUL) begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign bus.ready        = iso_en ? 1'b0 : ready_s;
    assign bus.busy         = iso_en ? 1'b0 : (state_r != ST_IDLE);
    assign bus.result       = iso_en ? '0 : result_r;
    assign bus.flags        = iso_en ? 5'b00000 : flags_r;
    assign bus.result_valid = iso_en ? 1'b0 : valid_r;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=16, MUL_LAT=4); covers the divider
// opcodes when ALU_MC_DIV_EN is defined and their illegal handling otherwise.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int WIDTH   = 16;
    localparam int MUL_LAT = 4;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0]  LONG_OP  = OP_DIV;
    localparam logic [15:0] LONG_A   = 16'd100;
    localparam logic [15:0] LONG_B   = 16'd7;
    localparam logic [15:0] LONG_RES = 16'd14;
    localparam int          LONG_LAT = WIDTH + 1;
    localparam int          DROP_AT  = 5;
`else
    localparam logic [3:0]  LONG_OP  = OP_MUL;
    localparam logic [15:0] LONG_A   = 16'd3;
    localparam logic [15:0] LONG_B   = 16'd5;
    localparam logic [15:0] LONG_RES = 16'd15;
    localparam int          LONG_LAT = MUL_LAT;
    localparam int          DROP_AT  = 2;
`endif

    logic clk = 1'b0;
    logic rst_n, alu_pwr_en, iso_en;
    int   total = 0;
    int   bad   = 0;

    alu_mc_if #(.WIDTH(WIDTH)) bus ();

    alu_mc #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.opcode = op;
        bus.A      = a;
        bus.B      = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // lat = cycle index (1 = the cycle right after the call point) where result_valid is seen; 0 on timeout.
    task automatic wait_valid(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        for (int c = 1; c <= 64; c++) begin
            if (bus.result_valid === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alu_pwr_en = 1'b1; iso_en = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.opcode = 4'd0;
        repeat (3) tick();
        total++; if ({bus.ready, bus.busy, bus.result_valid} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {bus.ready, bus.busy, bus.result_valid}); end
        total++; if ({bus.flags, bus.result} !== 21'd0) begin bad++; $display("FAIL reset_data: got %h want 0", {bus.flags, bus.result}); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", bus.ready); end
        tick();
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", bus.ready); end
    endtask

    // Issues land on consecutive edges, so this also covers back-to-back single-cycle ops.
    task automatic test_single_cycle();
        logic [3:0]  op_v [0:11];
        logic [15:0] a_v  [0:11];
        logic [15:0] b_v  [0:11];
        logic [15:0] r_v  [0:11];
        logic [4:0]  f_v  [0:11];
        op_v = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_XNOR, OP_ADD, OP_SUB, 4'd12, 4'd15};
        a_v  = '{16'hFFFF, 16'h0003, 16'hF0F0, 16'h1200, 16'h1234, 16'h0000, 16'h0001, 16'hAAAA, 16'h7FFF, 16'h0005, 16'h1234, 16'hFFFF};
        b_v  = '{16'h0001, 16'h0005, 16'h0FF0, 16'h0034, 16'h1234, 16'h0000, 16'h0013, 16'h5555, 16'h0001, 16'h0005, 16'h5678, 16'hFFFF};
        r_v  = '{16'h0000, 16'hFFFE, 16'h00F0, 16'h1234, 16'h0000, 16'hFFFF, 16'h0008, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
        f_v  = '{5'b00011, 5'b00010, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b10001, 5'b10001};
        for (int i = 0; i < 12; i++) begin
            issue(op_v[i], a_v[i], b_v[i]);
            total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL sc_valid[%0d]: got %b want 1", i, bus.result_valid); end
            total++; if (bus.result !== r_v[i]) begin bad++; $display("FAIL sc_result[%0d]: got %h want %h", i, bus.result, r_v[i]); end
            total++; if (bus.flags !== f_v[i]) begin bad++; $display("FAIL sc_flags[%0d]: got %b want %b", i, bus.flags, f_v[i]); end
            total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL sc_ready[%0d]: got %b want 1", i, bus.ready); end
        end
        tick();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL sc_pulse: got %b want 0", bus.result_valid); end
        total++; if (bus.flags !== 5'b10001) begin bad++; $display("FAIL sc_hold: got %b want 10001", bus.flags); end
    endtask

    task automatic test_mul();
        int lat, bc;
        issue(OP_MUL, 16'h0100, 16'h0100);
        total++; if ({bus.busy, bus.ready, bus.result_valid} !== 3'b100) begin bad++; $display("FAIL mul_first: got %b want 100", {bus.busy, bus.ready, bus.result_valid}); end
        issue(OP_ADD, 16'h0001, 16'h0001);
        wait_valid(lat, bc);
        total++; if (lat + 1 !== MUL_LAT) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat + 1, MUL_LAT); end
        total++; if (bc + 1 !== MUL_LAT - 1) begin bad++; $display("FAIL mul_busy: got %0d want %0d", bc + 1, MUL_LAT - 1); end
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL mul_ovf_result: got %h want 0000", bus.result); end
        total++; if (bus.flags !== 5'b00101) begin bad++; $display("FAIL mul_ovf_flags: got %b want 00101", bus.flags); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mul_ready: got %b want 1", bus.ready); end
        tick();
        total++; if ({bus.result_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL mul_after: got %b want 00", {bus.result_valid, bus.busy}); end
        issue(OP_MUL, 16'h0003, 16'h0005);
        wait_valid(lat, bc);
        total++; if ({lat, bus.result, bus.flags} !== {MUL_LAT, 16'h000F, 5'b00000}) begin bad++; $display("FAIL mul_small: got lat=%0d r=%h f=%b want lat=%0d r=000f f=00000", lat, bus.result, bus.flags, MUL_LAT); end
        issue(OP_MUL, 16'hFFFF, 16'hFFFF);
        wait_valid(lat, bc);
        total++; if ({bus.result, bus.flags} !== {16'h0001, 5'b00100}) begin bad++; $display("FAIL mul_max: got r=%h f=%b want r=0001 f=00100", bus.result, bus.flags); end
    endtask

`ifdef ALU_MC_DIV_EN
    task automatic test_div();
        int lat, bc;
        issue(OP_DIV, 16'd100, 16'd7);
        wait_valid(lat, bc);
        total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL div_latency: got %0d want %0d", lat, WIDTH + 1); end
        total++; if (bc !== WIDTH) begin bad++; $display("FAIL div_busy: got %0d want %0d", bc, WIDTH); end
        total++; if ({bus.result, bus.flags} !== {16'd14, 5'b00000}) begin bad++; $display("FAIL div_quot: got r=%h f=%b want r=000e f=00000", bus.result, bus.flags); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL div_ready: got %b want 1", bus.ready); end
        issue(OP_REM, 16'd100, 16'd7);
        wait_valid(lat, bc);
        total++; if ({lat, bus.result} !== {WIDTH + 1, 16'd2}) begin bad++; $display("FAIL rem_b2b: got lat=%0d r=%h want lat=%0d r=0002", lat, bus.result, WIDTH + 1); end
        issue(OP_DIV, 16'd5, 16'd9);
        wait_valid(lat, bc);
        total++; if ({bus.result, bus.flags} !== {16'd0, 5'b00001}) begin bad++; $display("FAIL div_zero_q: got r=%h f=%b want r=0000 f=00001", bus.result, bus.flags); end
        issue(OP_DIV, 16'h1234, 16'h0000);
        total++; if ({bus.result_valid, bus.result, bus.flags} !== {1'b1, 16'hFFFF, 5'b01000}) begin bad++; $display("FAIL div0_div: got v=%b r=%h f=%b want v=1 r=ffff f=01000", bus.result_valid, bus.result, bus.flags); end
        issue(OP_REM, 16'h1234, 16'h0000);
        total++; if ({bus.result_valid, bus.result, bus.flags} !== {1'b1, 16'h1234, 5'b01000}) begin bad++; $display("FAIL div0_rem: got v=%b r=%h f=%b want v=1 r=1234 f=01000", bus.result_valid, bus.result, bus.flags); end
    endtask
`else
    task automatic test_div();
        issue(OP_DIV, 16'h1234, 16'h0007);
        total++; if ({bus.result_valid, bus.busy, bus.result, bus.flags} !== {2'b10, 16'h0000, 5'b10001}) begin bad++; $display("FAIL div_illegal: got v=%b b=%b r=%h f=%b want v=1 b=0 r=0000 f=10001", bus.result_valid, bus.busy, bus.result, bus.flags); end
        issue(OP_REM, 16'h1234, 16'h0000);
        total++; if ({bus.result_valid, bus.busy, bus.result, bus.flags} !== {2'b10, 16'h0000, 5'b10001}) begin bad++; $display("FAIL rem_illegal: got v=%b b=%b r=%h f=%b want v=1 b=0 r=0000 f=10001", bus.result_valid, bus.busy, bus.result, bus.flags); end
    endtask
`endif

    task automatic test_power_down();
        int lat, bc, vcount, bcount;
        issue(OP_ADD, 16'h0010, 16'h0020);
        issue(LONG_OP, LONG_A, LONG_B);
        repeat (DROP_AT - 1) tick();
        alu_pwr_en = 1'b0;
        tick();
        total++; if ({bus.busy, bus.result_valid, bus.ready} !== 3'b000) begin bad++; $display("FAIL pwr_abort: got %b want 000", {bus.busy, bus.result_valid, bus.ready}); end
        total++; if (bus.result !== 16'h0030) begin bad++; $display("FAIL pwr_hold: got %h want 0030", bus.result); end
        vcount = 0; bcount = 0;
        bus.opcode = OP_ADD; bus.A = 16'h0001; bus.B = 16'h0001; bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.result_valid === 1'b1) vcount++;
            if (bus.busy === 1'b1) bcount++;
        end
        bus.start = 1'b0;
        total++; if ({vcount, bcount} !== {32'd0, 32'd0}) begin bad++; $display("FAIL pwr_off_quiet: got valid=%0d busy=%0d want 0 0", vcount, bcount); end
        alu_pwr_en = 1'b1;
        tick();
        total++; if ({bus.ready, bus.result} !== {1'b1, 16'h0030}) begin bad++; $display("FAIL pwr_up: got rdy=%b r=%h want rdy=1 r=0030", bus.ready, bus.result); end
        issue(LONG_OP, LONG_A, LONG_B);
        wait_valid(lat, bc);
        total++; if ({lat, bus.result} !== {LONG_LAT, LONG_RES}) begin bad++; $display("FAIL pwr_reissue: got lat=%0d r=%h want lat=%0d r=%h", lat, bus.result, LONG_LAT, LONG_RES); end
    endtask

    task automatic test_isolation();
        issue(OP_MUL, 16'h0007, 16'h0009);
        iso_en = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL iso_busy: got %b want 0", bus.busy); end
        repeat (MUL_LAT - 1) tick();
        total++; if ({bus.result_valid, bus.ready, bus.busy, bus.flags, bus.result} !== 24'd0) begin bad++; $display("FAIL iso_clamp: got %h want 0", {bus.result_valid, bus.ready, bus.busy, bus.flags, bus.result}); end
        tick();
        iso_en = 1'b0;
        #1;
        total++; if ({bus.result_valid, bus.ready, bus.flags, bus.result} !== {2'b01, 5'b00000, 16'h003F}) begin bad++; $display("FAIL iso_release: got v=%b rdy=%b f=%b r=%h want v=0 rdy=1 f=00000 r=003f", bus.result_valid, bus.ready, bus.flags, bus.result); end
        issue(4'd12, 16'h1234, 16'h5678);
        total++; if ({bus.result_valid, bus.result, bus.flags} !== {1'b1, 16'h0000, 5'b10001}) begin bad++; $display("FAIL illegal12: got v=%b r=%h f=%b want v=1 r=0000 f=10001", bus.result_valid, bus.result, bus.flags); end
    endtask

    task automatic test_reset_mid_op();
        issue(OP_MUL, 16'h0003, 16'h0005);
        rst_n = 1'b0;
        tick();
        total++; if ({bus.busy, bus.ready, bus.result_valid, bus.flags, bus.result} !== 24'd0) begin bad++; $display("FAIL reset_mid: got %h want 0", {bus.busy, bus.ready, bus.result_valid, bus.flags, bus.result}); end
        rst_n = 1'b1;
        tick();
        total++; if ({bus.ready, bus.busy} !== 2'b10) begin bad++; $display("FAIL reset_mid_release: got %b want 10", {bus.ready, bus.busy}); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_power_down();
        test_isolation();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
